regfile_param: RTL
==================

// Module: regfile_param
// PURPOSE
//   Parametrised multi-port register file for the single-cycle/multicycle CPU datapath.
//   - Two async read ports plus one debug read port; synchronous write.
//   - Register 0 hardwired to zero.
//   - After reset, an FSM sweeps the array to zero.
//   - A per-register pending-write scoreboard supports multicycle/pipelined control.
// PARAMETERS
//   DATA_W   32   register width in bits
//   ADDR_W   5    address width; DEPTH = 2**ADDR_W registers, index 0 reads 0
// PORTS
//   clk        in   1        single clock, all state updates on rising edge
//   reset      in   1        synchronous, active-high reset
//   ready      out  1        1 = sweep done, block accepts writes/issues
//   wen        in   1        write enable
//   waddr      in   ADDR_W   write address
//   wdata      in   DATA_W   write data
//   raddr1     in   ADDR_W   read port 1 address
//   rdata1     out  DATA_W   read port 1 data (combinational)
//   raddr2     in   ADDR_W   read port 2 address
//   rdata2     out  DATA_W   read port 2 data (combinational)
//   iss_en     in   1        mark register iss_addr as pending-write
//   iss_addr   in   ADDR_W   destination being issued
//   busy1      out  1        pending bit of raddr1
//   busy2      out  1        pending bit of raddr2
//   test_addr  in   ADDR_W   debug read address (board display)
//   test_data  out  DATA_W   debug read data (combinational)
// BEHAVIOUR
//   - One clock domain, clk. reset is synchronous and active-high.
//   - FSM states: INIT (sweep) and RUN.
//     - reset=1 at an edge: state<=INIT, clr_ptr<=1, all busy bits<=0. Applies from any state.
//     - INIT, reset=0: each edge writes rf[clr_ptr]<=0, then clr_ptr++.
//     - INIT->RUN on the edge that clears DEPTH-1 (ADDR_W=5: 31 edges after reset drops).
//       clr_ptr wraps to 0 on the transition.
//     - RUN is held until the next reset.
//   - ready = (state==RUN), registered. ready=0 during reset and throughout INIT.
//   - INIT cycles:
//     - wen and iss_en are ignored.
//     - rdata1, rdata2, test_data, busy1 and busy2 all read 0.
//   - Write (RUN only): wen=1 and waddr!=0 -> rf[waddr]<=wdata at the edge. waddr=0 is a no-op.
//   - Reads: rdataN = (raddrN==0) ? 0 : rf[raddrN]. Combinational, zero latency. test_data same rule.
//   - Scoreboard (RUN only), per register i!=0:
//     - set when iss_en && iss_addr==i
//     - cleared when wen && waddr==i
//     - set and clear same reg same edge -> set wins (new producer outstanding)
//     - busy bit of reg 0 is always 0; iss_en with iss_addr=0 is ignored
//     - busyN = pend[raddrN], combinational
//   - Same-cycle write+read of same addr: governed by REGFILE_BYPASS_EN.
//   - Reset mid-sweep restarts the sweep at 1. Reset in RUN discards pending bits
//     and re-zeroes the whole array.
// CONFIGURATION
//   REGFILE_BYPASS_EN defined:
//     - RUN, wen=1, waddr==raddrN!=0 -> rdataN=wdata in the same cycle.
//     - busyN is forced to 0 in that cycle (write-through).
//     - test_data is not bypassed.
//   REGFILE_BYPASS_EN undefined:
//     - rdataN shows the old rf value until the write edge.
//     - busyN shows the stored pending bit.
// TESTING
//   1. reset 1 cycle, then 0 -> ready=0 for 31 cycles, ready=1 on cycle 32.
//      Any raddr reads 0 throughout.
//   2. RUN: wen=1, waddr=5, wdata=32'hDEADBEEF; next cycle raddr1=5
//      -> rdata1=DEADBEEF, test_addr=5 -> test_data=DEADBEEF.
//   3. wen=1, waddr=0, wdata=32'h1234 -> raddr2=0 gives rdata2=0.
//      iss_en with iss_addr=0 -> busy stays 0.
//   4. iss_en, iss_addr=7 -> busy1=1 (raddr1=7) next cycle.
//      wen+iss_en both on addr 7 same edge -> busy1 stays 1.
//      wen alone on addr 7 -> busy1=0.
//   5. Same cycle: wen=1, waddr=3, wdata=32'hA5A5A5A5, raddr1=3, old rf[3]=0:
//      - with REGFILE_BYPASS_EN: rdata1=A5A5A5A5
//      - without it: rdata1=0
//   6. reset asserted at sweep cycle 10, then released -> ready rises after 31 more cycles.
//      Reset in RUN with rf[5] written -> rf[5]=0 and all busy bits 0 afterwards.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: two async read ports, one debug read port, synchronous write,
// post-reset zero sweep and per-register pending-write scoreboard. Optional macro: REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy1,
  output logic              busy2,
  input  logic [ADDR_W-1:0] test_addr,
  output logic [DATA_W-1:0] test_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_next;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  pend;

  logic              run;
  logic              wr_en;
  logic              iss_ok;
  logic [DEPTH-1:0]  set_mask;
  logic [DEPTH-1:0]  clr_mask;
  logic              byp1;
  logic              byp2;

  assign run    = (state == S_RUN);
  assign wr_en  = run && wen && (waddr != '0);
  assign iss_ok = run && iss_en && (iss_addr != '0);

  // Sweep FSM: clr_ptr walks 1..DEPTH-1; the final increment wraps it back to 0.
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      S_INIT: begin
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == {ADDR_W{1'b1}}) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        state_next = S_RUN;
      end
      default: begin
        state_next = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_INIT;
      clr_ptr <= ADDR_W'(1);
      ready   <= 1'b0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
      ready   <= (state_next == S_RUN);
    end
  end

  // Entry 0 is never written; every read of index 0 is forced to zero instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!run) begin
        rf[clr_ptr] <= '0;
      end else if (wr_en) begin
        rf[waddr] <= wdata;
      end
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_ok) begin
      set_mask = DEPTH'(1) << iss_addr;
    end
    if (wr_en) begin
      clr_mask = DEPTH'(1) << waddr;
    end
  end

  // A new issue to a register that is retiring this edge leaves it pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else if (run) begin
      pend <= ((pend & ~clr_mask) | set_mask) & ~DEPTH'(1);
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign byp1 = wr_en && (waddr == raddr1);
  assign byp2 = wr_en && (waddr == raddr2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    rdata1    = '0;
    rdata2    = '0;
    test_data = '0;
    busy1     = 1'b0;
    busy2     = 1'b0;
    if (run) begin
      if (raddr1 != '0) begin
        rdata1 = byp1 ? wdata : rf[raddr1];
        busy1  = pend[raddr1] && !byp1;
      end
      if (raddr2 != '0) begin
        rdata2 = byp2 ? wdata : rf[raddr2];
        busy2  = pend[raddr2] && !byp2;
      end
      if (test_addr != '0) begin
        test_data = rf[test_addr];
      end
    end
  end

endmodule
